sram_bus_arbiter: RTL

//   Shares one external SRAM-like bus between the instruction-fetch port and the

---
 rtl/sram_bus_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// Purpose : shares one SRAM-like bus between the fetch port and the data port; data has priority, fetch is forced after STARVE_LIMIT data grants.
// Latency : request sampled in cycle N, address phase in N+1, ack in N+2 minimum; each address/data wait cycle adds one.
// Backpres: requesters hold req until their one-cycle ack; stall_if/stall_mem stay high while a port waits; bus waits via addr_ok/data_ok.
//
// Ports:
//   clka, rst                  clock, async active-low reset
//   if_req/if_addr             fetch request (level) and address; if_rdata/if_ack result
//   mem_req/wen/addr/wdata     data request (level), byte mask (0 = read); mem_rdata/mem_ack result
//   bus_req/wr/wstrb/addr/wdata  registered address-phase outputs toward the SRAM bus
//   bus_addr_ok/data_ok/rdata  bus handshake and read data
//   stall_if, stall_mem        stall requests into the hazard unit
module sram_bus_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int AW           = 32
) (
   input  logic          clka,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [31:0]   if_rdata,
   output logic          if_ack,
   input  logic          mem_req,
   input  logic [3:0]    mem_wen,
   input  logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_wdata,
   output logic [31:0]   mem_rdata,
   output logic          mem_ack,
   output logic          bus_req,
   output logic          bus_wr,
   output logic [3:0]    bus_wstrb,
   output logic [AW-1:0] bus_addr,
   output logic [31:0]   bus_wdata,
   input  logic          bus_addr_ok,
   input  logic          bus_data_ok,
   input  logic [31:0]   bus_rdata,
   output logic          stall_if,
   output logic          stall_mem
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   localparam int             SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic           OWN_IF     = 1'b0;
   localparam logic           OWN_MEM    = 1'b1;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic            bus_req_q, bus_req_d;
   logic            bus_wr_q, bus_wr_d;
   logic [3:0]      bus_wstrb_q, bus_wstrb_d;
   logic [AW-1:0]   bus_addr_q, bus_addr_d;
   logic [31:0]     bus_wdata_q, bus_wdata_d;
   logic [31:0]     if_rdata_q, if_rdata_d;
   logic [31:0]     mem_rdata_q, mem_rdata_d;
   logic            grant_mem, grant_if, capture;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      starve_d    = starve_q;
      bus_req_d   = bus_req_q;
      bus_wr_d    = bus_wr_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      grant_mem   = 1'b0;
      grant_if    = 1'b0;
      capture     = 1'b0;

      case (state_q)
         IDLE: begin
            // Data wins unless fetch is pending and has been passed over too often.
            grant_mem = mem_req && ((starve_q < STARVE_MAX) || !if_req);
            grant_if  = if_req && !grant_mem;
            if (!if_req) begin
               starve_d = '0;
            end
            if (grant_mem) begin
               state_d     = ADDR;
               owner_d     = OWN_MEM;
               bus_req_d   = 1'b1;
               bus_wr_d    = |mem_wen;
               bus_wstrb_d = mem_wen;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
               if (if_req && (starve_q != STARVE_MAX)) begin
                  starve_d = starve_q + SW'(1);
               end
            end else if (grant_if) begin
               state_d     = ADDR;
               owner_d     = OWN_IF;
               bus_req_d   = 1'b1;
               bus_wr_d    = 1'b0;
               bus_wstrb_d = 4'b0000;
               bus_addr_d  = if_addr;
               bus_wdata_d = 32'h0;
               starve_d    = '0;
            end
         end
         ADDR: begin
            if (bus_addr_ok) begin
               bus_req_d = 1'b0;
               // A bus that completes data together with the address skips DATA.
               if (bus_data_ok) begin
                  capture = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (bus_data_ok) begin
               capture = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // Never grant here so a requester still holding req is not served twice.
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (capture) begin
         if (owner_q == OWN_IF) begin
            if_rdata_d = bus_rdata;
         end else if (!bus_wr_q) begin
            mem_rdata_d = bus_rdata;
         end
      end
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         starve_q    <= '0;
         bus_req_q   <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_wstrb_q <= 4'b0000;
         bus_addr_q  <= '0;
         bus_wdata_q <= 32'h0;
         if_rdata_q  <= 32'h0;
         mem_rdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         bus_req_q   <= bus_req_d;
         bus_wr_q    <= bus_wr_d;
         bus_wstrb_q <= bus_wstrb_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign if_ack    = (state_q == DONE) && (owner_q == OWN_IF);
   assign mem_ack   = (state_q == DONE) && (owner_q == OWN_MEM);
   assign if_rdata  = if_rdata_q;
   assign mem_rdata = mem_rdata_q;
   assign bus_req   = bus_req_q;
   assign bus_wr    = bus_wr_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = mem_req & ~mem_ack;

endmodule
